// File: rtl/spi_sck_sequencer.sv
// Burst SCK generator (SPI mode 0): N clock periods per request at a slow or fast half-period H.
// Latency: o_busy one cycle after i_start; first rise H cycles later; o_done (2N+1)H cycles after o_busy.
// No backpressure: i_start is dropped while busy; SCK_HOLD_EN adds i_hold to stretch SCK low phases.
module spi_sck_sequencer #(
  parameter int SLOW_HALF = 4,
  parameter int FAST_HALF = 1,
  parameter int CNT_W     = $clog2((SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF) + 1
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [3:0] i_nbits,
  input  logic       i_rate_sel,
`ifdef SCK_HOLD_EN
  input  logic       i_hold,
`endif
  output logic       o_sck,
  output logic       o_sample,
  output logic       o_shift,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;

  state_t           state;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hlast;
  logic [4:0]       nbits;
  logic [4:0]       bits_done;
  logic [4:0]       bits_nxt;
  logic             half_end;
  logic             hold_low;

  assign half_end = (hcnt == hlast);
  assign bits_nxt = bits_done + 5'd1;

`ifdef SCK_HOLD_EN
  assign hold_low = i_hold;
`else
  assign hold_low = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hcnt      <= '0;
      hlast     <= '0;
      nbits     <= '0;
      bits_done <= '0;
      o_sck     <= 1'b0;
      o_sample  <= 1'b0;
      o_shift   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_sample <= 1'b0;
      o_shift  <= 1'b0;
      o_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            hlast     <= i_rate_sel ? CNT_W'(FAST_HALF - 1) : CNT_W'(SLOW_HALF - 1);
            nbits     <= (i_nbits == 4'd0) ? 5'd16 : {1'b0, i_nbits};
            bits_done <= '0;
            hcnt      <= '0;
            o_busy    <= 1'b1;
            state     <= LEAD;
          end
        end
        LEAD: begin
          if (half_end) begin
            hcnt     <= '0;
            o_sck    <= 1'b1;
            o_sample <= 1'b1;
            state    <= HIGH;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        HIGH: begin
          if (half_end) begin
            hcnt      <= '0;
            o_sck     <= 1'b0;
            bits_done <= bits_nxt;
            if (bits_nxt < nbits) begin
              o_shift <= 1'b1;
              state   <= LOW;
            end else begin
              state <= TRAIL;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        LOW: begin
          // A held low phase freezes the counter, even on its final count.
          if (!hold_low) begin
            if (half_end) begin
              hcnt     <= '0;
              o_sck    <= 1'b1;
              o_sample <= 1'b1;
              state    <= HIGH;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
        end
        TRAIL: begin
          if (half_end) begin
            hcnt   <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= IDLE;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
